// File: rtl/cs_pkg.sv
// Shared constants for the hardwired control sequencer: opcodes, ALU codes,
// FSM states and the ctl strobe bus layout.
package cs_pkg;

    localparam int unsigned OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_JR   = 5'b10100;
    localparam logic [OPC_W-1:0] OP_JAL  = 5'b10101;
    localparam logic [OPC_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;

    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalted, StFault
    } state_t;

    // ctl bus bit indices, one per DataPath strobe
    localparam int unsigned CTL_W        = 22;
    localparam int unsigned CTL_PCOUT    = 0;
    localparam int unsigned CTL_MARIN    = 1;
    localparam int unsigned CTL_INCPC    = 2;
    localparam int unsigned CTL_ZLOWIN   = 3;
    localparam int unsigned CTL_ZLOWOUT  = 4;
    localparam int unsigned CTL_PCIN     = 5;
    localparam int unsigned CTL_READ     = 6;
    localparam int unsigned CTL_MD_READ  = 7;
    localparam int unsigned CTL_MDRIN    = 8;
    localparam int unsigned CTL_MDROUT   = 9;
    localparam int unsigned CTL_IRIN     = 10;
    localparam int unsigned CTL_GRA      = 11;
    localparam int unsigned CTL_GRB      = 12;
    localparam int unsigned CTL_GRC      = 13;
    localparam int unsigned CTL_RIN      = 14;
    localparam int unsigned CTL_ROUT     = 15;
    localparam int unsigned CTL_BAOUT    = 16;
    localparam int unsigned CTL_CSIGNOUT = 17;
    localparam int unsigned CTL_YIN      = 18;
    localparam int unsigned CTL_LINKSEL  = 19;
    localparam int unsigned CTL_CONIN    = 20;
    localparam int unsigned CTL_WRITE    = 21;

    typedef logic [CTL_W-1:0] ctl_t;

    // Single-strobe masks, OR-ed together by the decoder
    localparam ctl_t M_PCOUT    = CTL_W'(1) << CTL_PCOUT;
    localparam ctl_t M_MARIN    = CTL_W'(1) << CTL_MARIN;
    localparam ctl_t M_INCPC    = CTL_W'(1) << CTL_INCPC;
    localparam ctl_t M_ZLOWIN   = CTL_W'(1) << CTL_ZLOWIN;
    localparam ctl_t M_ZLOWOUT  = CTL_W'(1) << CTL_ZLOWOUT;
    localparam ctl_t M_PCIN     = CTL_W'(1) << CTL_PCIN;
    localparam ctl_t M_READ     = CTL_W'(1) << CTL_READ;
    localparam ctl_t M_MD_READ  = CTL_W'(1) << CTL_MD_READ;
    localparam ctl_t M_MDRIN    = CTL_W'(1) << CTL_MDRIN;
    localparam ctl_t M_MDROUT   = CTL_W'(1) << CTL_MDROUT;
    localparam ctl_t M_IRIN     = CTL_W'(1) << CTL_IRIN;
    localparam ctl_t M_GRA      = CTL_W'(1) << CTL_GRA;
    localparam ctl_t M_GRB      = CTL_W'(1) << CTL_GRB;
    localparam ctl_t M_GRC      = CTL_W'(1) << CTL_GRC;
    localparam ctl_t M_RIN      = CTL_W'(1) << CTL_RIN;
    localparam ctl_t M_ROUT     = CTL_W'(1) << CTL_ROUT;
    localparam ctl_t M_BAOUT    = CTL_W'(1) << CTL_BAOUT;
    localparam ctl_t M_CSIGNOUT = CTL_W'(1) << CTL_CSIGNOUT;
    localparam ctl_t M_YIN      = CTL_W'(1) << CTL_YIN;
    localparam ctl_t M_LINKSEL  = CTL_W'(1) << CTL_LINKSEL;
    localparam ctl_t M_CONIN    = CTL_W'(1) << CTL_CONIN;
    localparam ctl_t M_WRITE    = CTL_W'(1) << CTL_WRITE;

    // Debug T-step number; non-T states report 0
    function automatic logic [3:0] state_step(state_t s);
        logic [3:0] n;
        n = 4'd0;
        case (s)
            StT1:    n = 4'd1;
            StT2:    n = 4'd2;
            StT3:    n = 4'd3;
            StT4:    n = 4'd4;
            StT5:    n = 4'd5;
            StT6:    n = 4'd6;
            StT7:    n = 4'd7;
            default: n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/cs_decode.sv
// Combinational strobe decoder: maps (state, opcode, con_ff) to the ctl bus and alu_op.
module cs_decode
    import cs_pkg::*;
#(
    parameter int unsigned ALU_OP_W = 4
) (
    input  state_t              state,
    input  logic [OPC_W-1:0]    opcode,
    input  logic                con_ff,
    output logic [CTL_W-1:0]    ctl,
    output logic [ALU_OP_W-1:0] alu_op
);

    function automatic logic [ALU_OP_W-1:0] alu_of(logic [OPC_W-1:0] op);
        logic [3:0] a;
        case (op)
            OP_SUB:  a = ALU_SUB;
            OP_AND:  a = ALU_AND;
            OP_OR:   a = ALU_OR;
            default: a = ALU_ADD;
        endcase
        return ALU_OP_W'(a);
    endfunction

    // Strobes per state; anything not listed (IDLE, HALTED, FAULT, HALT/illegal T3) is all-low
    always_comb begin
        ctl    = '0;
        alu_op = ALU_OP_W'(ALU_NOP);
        case (state)
            StT0: ctl = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;
            StT1: ctl = M_ZLOWOUT | M_PCIN | M_READ | M_MD_READ | M_MDRIN;
            StT2: ctl = M_MDROUT | M_IRIN;
            StT3: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST:          ctl = M_GRB | M_BAOUT | M_YIN;
                    OP_ADD, OP_SUB, OP_AND, OP_OR: ctl = M_GRB | M_ROUT | M_YIN;
                    OP_JR:                         ctl = M_GRA | M_ROUT | M_PCIN;
                    OP_JAL:                        ctl = M_PCOUT | M_LINKSEL | M_RIN;
                    OP_BR:                         ctl = M_GRA | M_ROUT | M_CONIN;
                    default:                       ctl = '0;
                endcase
            end
            StT4: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin
                        ctl    = M_CSIGNOUT | M_ZLOWIN;
                        alu_op = ALU_OP_W'(ALU_ADD);
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        ctl    = M_GRC | M_ROUT | M_ZLOWIN;
                        alu_op = alu_of(opcode);
                    end
                    OP_JAL:  ctl = M_GRA | M_ROUT | M_PCIN;
                    OP_BR:   ctl = M_PCOUT | M_YIN;
                    default: ctl = '0;
                endcase
            end
            StT5: begin
                case (opcode)
                    OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR: ctl = M_ZLOWOUT | M_GRA | M_RIN;
                    OP_LD, OP_ST:                          ctl = M_ZLOWOUT | M_MARIN;
                    OP_BR: begin
                        ctl    = M_CSIGNOUT | M_ZLOWIN;
                        alu_op = ALU_OP_W'(ALU_ADD);
                    end
                    default: ctl = '0;
                endcase
            end
            StT6: begin
                case (opcode)
                    OP_LD:   ctl = M_READ | M_MD_READ | M_MDRIN;
                    // MD_read stays low so MDR captures the register bus
                    OP_ST:   ctl = M_GRA | M_ROUT | M_MDRIN;
                    OP_BR:   ctl = M_ZLOWOUT | (con_ff ? M_PCIN : '0);
                    default: ctl = '0;
                endcase
            end
            StT7: begin
                case (opcode)
                    OP_LD:   ctl = M_MDROUT | M_GRA | M_RIN;
                    OP_ST:   ctl = M_WRITE;
                    default: ctl = '0;
                endcase
            end
            default: ctl = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch/decode/execute FSM with memory ready handshake,
// timeout, run/stop control and sticky HALTED/FAULT states.
module control_sequencer
    import cs_pkg::*;
#(
    parameter int unsigned INSTR_W     = 32,
    parameter int unsigned OPCODE_W    = 5,
    parameter int unsigned ALU_OP_W    = 4,
    parameter int unsigned MEM_WAIT_EN = 1,
    parameter int unsigned MAX_WAIT    = 15
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic [INSTR_W-1:0]  ir,
    input  logic                con_ff,
    input  logic                mem_ready,
    output logic [CTL_W-1:0]    ctl,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [3:0]          step,
    output logic                halted,
    output logic                fault
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [OPC_W-1:0]  opcode;
    logic              is_mem_step;
    logic              end_instr;
    logic              unused_ir;

    assign opcode    = OPC_W'(ir[INSTR_W-1 -: OPCODE_W]);
    assign unused_ir = ^ir[INSTR_W-OPCODE_W-1:0];

    // State and wait counter registers
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= StIdle;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state: instruction sequencing, then memory-wait override
    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        is_mem_step = 1'b0;
        end_instr   = 1'b0;
        case (state_q)
            StIdle: if (run) state_d = StT0;
            StT0:   state_d = StT1;
            StT1: begin
                is_mem_step = 1'b1;
                state_d     = StT2;
            end
            StT2: begin
                if (opcode == OP_NOP) end_instr = 1'b1;
                else                  state_d   = StT3;
            end
            StT3: begin
                case (opcode)
                    OP_HALT: state_d   = StHalted;
                    OP_JR:   end_instr = 1'b1;
                    OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_JAL, OP_BR:
                        state_d = StT4;
                    default: state_d = StFault;
                endcase
            end
            StT4: begin
                case (opcode)
                    OP_JAL: end_instr = 1'b1;
                    OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_BR:
                        state_d = StT5;
                    default: state_d = StFault;
                endcase
            end
            StT5: begin
                case (opcode)
                    OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR: end_instr = 1'b1;
                    OP_LD, OP_ST, OP_BR:                   state_d   = StT6;
                    default:                               state_d   = StFault;
                endcase
            end
            StT6: begin
                case (opcode)
                    OP_BR: end_instr = 1'b1;
                    OP_LD: begin
                        is_mem_step = 1'b1;
                        state_d     = StT7;
                    end
                    OP_ST:   state_d = StT7;
                    default: state_d = StFault;
                endcase
            end
            StT7: begin
                case (opcode)
                    OP_LD: end_instr = 1'b1;
                    OP_ST: begin
                        is_mem_step = 1'b1;
                        end_instr   = 1'b1;
                    end
                    default: state_d = StFault;
                endcase
            end
            StHalted: state_d = StHalted;
            StFault:  state_d = StFault;
            default:  state_d = StFault;
        endcase

        if (end_instr) state_d = run ? StT0 : StIdle;

        // Hold the memory step until ready; give up after MAX_WAIT idle cycles
        if (is_mem_step && (MEM_WAIT_EN != 0) && !mem_ready) begin
            if (wait_q == WAIT_W'(MAX_WAIT)) begin
                state_d = StFault;
            end else begin
                state_d = state_q;
                wait_d  = wait_q + WAIT_W'(1);
            end
        end
    end

    cs_decode #(
        .ALU_OP_W(ALU_OP_W)
    ) u_decode (
        .state (state_q),
        .opcode(opcode),
        .con_ff(con_ff),
        .ctl   (ctl),
        .alu_op(alu_op)
    );

    // Status outputs decoded from registered state
    always_comb begin
        step   = state_step(state_q);
        halted = (state_q == StHalted);
        fault  = (state_q == StFault);
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed vector table, hand-written
// multi-cycle sequences and randomized run against a microprogram-list reference model.
module tb_control_sequencer;
    import cs_pkg::*;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned MAX_WAIT = 15;

    logic              clock = 1'b0;
    logic              clear, run, con_ff, mem_ready;
    logic [INSTR_W-1:0] ir;
    logic [CTL_W-1:0]  ctl;
    logic [3:0]        alu_op;
    logic [3:0]        step;
    logic              halted, fault;

    int n_tests = 0;
    int n_fail  = 0;

    control_sequencer #(
        .INSTR_W    (INSTR_W),
        .OPCODE_W   (5),
        .ALU_OP_W   (4),
        .MEM_WAIT_EN(1),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .run      (run),
        .ir       (ir),
        .con_ff   (con_ff),
        .mem_ready(mem_ready),
        .ctl      (ctl),
        .alu_op   (alu_op),
        .step     (step),
        .halted   (halted),
        .fault    (fault)
    );

    always #5 clock = ~clock;

    // Bench-side strobe masks built from the bus bit indices
    localparam ctl_t B_PCOUT = ctl_t'(1) << CTL_PCOUT;
    localparam ctl_t B_MARIN = ctl_t'(1) << CTL_MARIN;
    localparam ctl_t B_INCPC = ctl_t'(1) << CTL_INCPC;
    localparam ctl_t B_ZIN   = ctl_t'(1) << CTL_ZLOWIN;
    localparam ctl_t B_ZOUT  = ctl_t'(1) << CTL_ZLOWOUT;
    localparam ctl_t B_PCIN  = ctl_t'(1) << CTL_PCIN;
    localparam ctl_t B_READ  = ctl_t'(1) << CTL_READ;
    localparam ctl_t B_MDRD  = ctl_t'(1) << CTL_MD_READ;
    localparam ctl_t B_MDRIN = ctl_t'(1) << CTL_MDRIN;
    localparam ctl_t B_MDROUT = ctl_t'(1) << CTL_MDROUT;
    localparam ctl_t B_IRIN  = ctl_t'(1) << CTL_IRIN;
    localparam ctl_t B_GRA   = ctl_t'(1) << CTL_GRA;
    localparam ctl_t B_GRB   = ctl_t'(1) << CTL_GRB;
    localparam ctl_t B_GRC   = ctl_t'(1) << CTL_GRC;
    localparam ctl_t B_RIN   = ctl_t'(1) << CTL_RIN;
    localparam ctl_t B_ROUT  = ctl_t'(1) << CTL_ROUT;
    localparam ctl_t B_BAOUT = ctl_t'(1) << CTL_BAOUT;
    localparam ctl_t B_CSIGN = ctl_t'(1) << CTL_CSIGNOUT;
    localparam ctl_t B_YIN   = ctl_t'(1) << CTL_YIN;
    localparam ctl_t B_LINK  = ctl_t'(1) << CTL_LINKSEL;
    localparam ctl_t B_CONIN = ctl_t'(1) << CTL_CONIN;
    localparam ctl_t B_WRITE = ctl_t'(1) << CTL_WRITE;

    localparam ctl_t F0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam ctl_t F1 = B_ZOUT | B_PCIN | B_READ | B_MDRD | B_MDRIN;
    localparam ctl_t F2 = B_MDROUT | B_IRIN;
    localparam ctl_t DRIVERS = B_PCOUT | B_ZOUT | B_MDROUT | B_ROUT | B_BAOUT | B_CSIGN;

    localparam logic [4:0] OP_BAD = 5'b11111;

    // ---------------- reference model ----------------
    // Each instruction is a list of per-step {ctl, alu} words; the model walks the list.
    typedef enum int {MIdle, MRun, MHalt, MFault} mmode_t;
    mmode_t     m_mode;
    int         m_k;
    int         m_wait;
    ctl_t       sc[$];
    logic [3:0] sa[$];
    int         fin;    // what happens after the last step: 0 next/idle, 1 halt, 2 fault

    function automatic void push(ctl_t c, logic [3:0] a);
        sc.push_back(c);
        sa.push_back(a);
    endfunction

    function automatic void build(logic [4:0] op, logic con);
        logic [3:0] aop;
        sc.delete();
        sa.delete();
        fin = 0;
        push(F0, ALU_NOP);
        push(F1, ALU_NOP);
        push(F2, ALU_NOP);
        case (op)
            OP_NOP: ;
            OP_LDI, OP_LD, OP_ST: begin
                push(B_GRB | B_BAOUT | B_YIN, ALU_NOP);
                push(B_CSIGN | B_ZIN, ALU_ADD);
                if (op == OP_LDI) begin
                    push(B_ZOUT | B_GRA | B_RIN, ALU_NOP);
                end else begin
                    push(B_ZOUT | B_MARIN, ALU_NOP);
                    if (op == OP_LD) begin
                        push(B_READ | B_MDRD | B_MDRIN, ALU_NOP);
                        push(B_MDROUT | B_GRA | B_RIN, ALU_NOP);
                    end else begin
                        push(B_GRA | B_ROUT | B_MDRIN, ALU_NOP);
                        push(B_WRITE, ALU_NOP);
                    end
                end
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                aop = (op == OP_ADD) ? ALU_ADD : (op == OP_SUB) ? ALU_SUB :
                      (op == OP_AND) ? ALU_AND : ALU_OR;
                push(B_GRB | B_ROUT | B_YIN, ALU_NOP);
                push(B_GRC | B_ROUT | B_ZIN, aop);
                push(B_ZOUT | B_GRA | B_RIN, ALU_NOP);
            end
            OP_JR:  push(B_GRA | B_ROUT | B_PCIN, ALU_NOP);
            OP_JAL: begin
                push(B_PCOUT | B_LINK | B_RIN, ALU_NOP);
                push(B_GRA | B_ROUT | B_PCIN, ALU_NOP);
            end
            OP_BR: begin
                push(B_GRA | B_ROUT | B_CONIN, ALU_NOP);
                push(B_PCOUT | B_YIN, ALU_NOP);
                push(B_CSIGN | B_ZIN, ALU_ADD);
                push(B_ZOUT | (con ? B_PCIN : ctl_t'(0)), ALU_NOP);
            end
            OP_HALT: begin
                push('0, ALU_NOP);
                fin = 1;
            end
            default: begin
                push('0, ALU_NOP);
                fin = 2;
            end
        endcase
    endfunction

    function automatic logic [4:0] cur_op();
        return ir[INSTR_W-1 -: 5];
    endfunction

    function automatic bit mem_step(logic [4:0] op, int k);
        return (k == 1) || (op == OP_LD && k == 6) || (op == OP_ST && k == 7);
    endfunction

    function automatic void model_reset();
        m_mode = MIdle;
        m_k    = 0;
        m_wait = 0;
    endfunction

    // Advance the model by one clock using the inputs currently applied
    function automatic void model_tick();
        logic [4:0] op;
        op = cur_op();
        case (m_mode)
            MIdle: if (run) begin
                m_mode = MRun;
                m_k    = 0;
                m_wait = 0;
            end
            MRun: begin
                build(op, con_ff);
                if (mem_step(op, m_k) && !mem_ready) begin
                    if (m_wait == MAX_WAIT) begin
                        m_mode = MFault;
                        m_wait = 0;
                    end else begin
                        m_wait++;
                    end
                end else begin
                    m_wait = 0;
                    m_k++;
                    if (m_k == sc.size()) begin
                        m_k = 0;
                        if (fin == 1)      m_mode = MHalt;
                        else if (fin == 2) m_mode = MFault;
                        else               m_mode = run ? MRun : MIdle;
                    end
                end
            end
            default: ;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        ctl_t       ec;
        logic [3:0] ea, es;
        ec = '0;
        ea = ALU_NOP;
        es = 4'd0;
        if (m_mode == MRun) begin
            build(cur_op(), con_ff);
            ec = sc[m_k];
            ea = sa[m_k];
            es = 4'(m_k);
        end
        chk("step", 32'(step), 32'(es));
        chk("ctl", 32'(ctl), 32'(ec));
        chk("alu_op", 32'(alu_op), 32'(ea));
        chk("halted", 32'(halted), 32'(m_mode == MHalt));
        chk("fault", 32'(fault), 32'(m_mode == MFault));
        chk("one_driver", 32'($countones(ctl & DRIVERS) <= 1), 32'd1);
        chk("rd_wr_excl", 32'(ctl[CTL_READ] & ctl[CTL_WRITE]), 32'd0);
    endtask

    ctl_t       last_ctl;
    logic [3:0] last_step;
    logic [3:0] last_alu;
    logic       last_halted, last_fault;

    // One clock: drive at negedge, compare against the model, then advance the model
    task automatic cycle(input logic r, input logic [4:0] op, input logic c, input logic mr);
        @(negedge clock);
        run       = r;
        ir        = {op, 27'($urandom())};
        con_ff    = c;
        mem_ready = mr;
        #1;
        check_outputs();
        last_ctl    = ctl;
        last_step   = step;
        last_alu    = alu_op;
        last_halted = halted;
        last_fault  = fault;
        @(posedge clock);
        model_tick();
    endtask

    task automatic do_reset();
        @(negedge clock);
        clear     = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b1;
        con_ff    = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clock);
        clear = 1'b1;
    endtask

    function automatic logic [4:0] pick_op();
        logic [4:0] legal [11];
        int r;
        legal = '{OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_JR, OP_JAL, OP_BR,
                  OP_NOP};
        r = $urandom_range(0, 99);
        if (r < 3) return OP_HALT;
        if (r < 5) return OP_BAD;
        if (r < 6) return 5'b01000;
        return legal[$urandom_range(0, 10)];
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       clr;
        logic       r;
        logic [4:0] op;
        logic       c;
        logic       mr;
        logic [3:0] es;
        ctl_t       ec;
        logic [3:0] ea;
        logic       eh;
        logic       ef;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [4:0] rop;
        int stuck;

        clear = 1'b0; run = 1'b0; ir = '0; con_ff = 1'b0; mem_ready = 1'b1;
        model_reset();

        // LDI with mem_ready high, then an undefined opcode
        tbl[0]  = '{1'b0, 1'b0, OP_LDI, 1'b0, 1'b1, 4'd0, ctl_t'(0), ALU_NOP, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, OP_LDI, 1'b0, 1'b1, 4'd0, ctl_t'(0), ALU_NOP, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, OP_LDI, 1'b0, 1'b1, 4'd0, F0, ALU_NOP, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, OP_LDI, 1'b0, 1'b1, 4'd1, F1, ALU_NOP, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, OP_LDI, 1'b0, 1'b1, 4'd2, F2, ALU_NOP, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, OP_LDI, 1'b0, 1'b1, 4'd3, B_GRB | B_BAOUT | B_YIN,
                    ALU_NOP, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, OP_LDI, 1'b0, 1'b1, 4'd4, B_CSIGN | B_ZIN, ALU_ADD, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, OP_LDI, 1'b0, 1'b1, 4'd5, B_ZOUT | B_GRA | B_RIN,
                    ALU_NOP, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, OP_BAD, 1'b0, 1'b1, 4'd0, F0, ALU_NOP, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, OP_BAD, 1'b0, 1'b1, 4'd1, F1, ALU_NOP, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, OP_BAD, 1'b0, 1'b1, 4'd2, F2, ALU_NOP, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, OP_BAD, 1'b0, 1'b1, 4'd3, ctl_t'(0), ALU_NOP, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, OP_BAD, 1'b0, 1'b1, 4'd0, ctl_t'(0), ALU_NOP, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, OP_BAD, 1'b0, 1'b1, 4'd0, ctl_t'(0), ALU_NOP, 1'b0, 1'b1};

        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            clear     = tbl[i].clr;
            run       = tbl[i].r;
            ir        = {tbl[i].op, 27'd0};
            con_ff    = tbl[i].c;
            mem_ready = tbl[i].mr;
            #1;
            chk($sformatf("vec%0d step", i), 32'(step), 32'(tbl[i].es));
            chk($sformatf("vec%0d ctl", i), 32'(ctl), 32'(tbl[i].ec));
            chk($sformatf("vec%0d alu", i), 32'(alu_op), 32'(tbl[i].ea));
            chk($sformatf("vec%0d halted", i), 32'(halted), 32'(tbl[i].eh));
            chk($sformatf("vec%0d fault", i), 32'(fault), 32'(tbl[i].ef));
        end
        do_reset();

        // LD: mem_ready low for 4 cycles in T6 holds step 6 for 5 cycles
        cycle(1, OP_LD, 0, 1);
        for (int k = 0; k < 6; k++) cycle(1, OP_LD, 0, 1);
        for (int j = 0; j < 4; j++) begin
            cycle(1, OP_LD, 0, 0);
            chk("ld_hold_step", 32'(last_step), 32'd6);
        end
        cycle(1, OP_LD, 0, 1);
        chk("ld_ready_step", 32'(last_step), 32'd6);
        cycle(0, OP_LD, 0, 1);
        chk("ld_t7_step", 32'(last_step), 32'd7);
        chk("ld_t7_ctl", 32'(last_ctl), 32'(B_MDROUT | B_GRA | B_RIN));
        cycle(0, OP_LD, 0, 1);
        chk("ld_idle_step", 32'(last_step), 32'd0);

        // Fetch T1 timeout: 16 cycles of mem_ready low then FAULT
        cycle(1, OP_ADD, 0, 1);
        cycle(1, OP_ADD, 0, 1);
        for (int j = 0; j < 16; j++) begin
            cycle(1, OP_ADD, 0, 0);
            chk("t1_hold_step", 32'(last_step), 32'd1);
        end
        cycle(1, OP_ADD, 0, 0);
        chk("timeout_fault", 32'(last_fault), 32'd1);
        chk("timeout_ctl", 32'(last_ctl), 32'd0);
        do_reset();

        // BR taken then not taken
        cycle(1, OP_BR, 0, 1);
        for (int k = 0; k < 7; k++) cycle(1, OP_BR, 1, 1);
        chk("br_taken_pcin", 32'(last_ctl), 32'(B_ZOUT | B_PCIN));
        for (int k = 0; k < 7; k++) cycle(k != 6, OP_BR, 0, 1);
        chk("br_not_taken", 32'(last_ctl), 32'(B_ZOUT));
        cycle(0, OP_NOP, 0, 1);
        chk("br_idle", 32'(last_ctl), 32'd0);

        // JAL then JR back through R15
        cycle(1, OP_JAL, 0, 1);
        for (int k = 0; k < 5; k++) begin
            cycle(1, OP_JAL, 0, 1);
            if (k == 3) chk("jal_t3", 32'(last_ctl), 32'(B_PCOUT | B_LINK | B_RIN));
            if (k == 4) chk("jal_t4", 32'(last_ctl), 32'(B_GRA | B_ROUT | B_PCIN));
        end
        for (int k = 0; k < 4; k++) cycle(k != 3, OP_JR, 0, 1);
        chk("jr_t3", 32'(last_ctl), 32'(B_GRA | B_ROUT | B_PCIN));
        cycle(0, OP_NOP, 0, 1);

        // HALT is sticky across run toggling
        cycle(1, OP_HALT, 0, 1);
        for (int k = 0; k < 4; k++) cycle(1, OP_HALT, 0, 1);
        for (int j = 0; j < 6; j++) begin
            cycle(j[0], OP_ADD, 0, 1);
            chk("halt_sticky", 32'(last_halted), 32'd1);
            chk("halt_ctl", 32'(last_ctl), 32'd0);
        end
        do_reset();

        // Async clear during ADD T4
        cycle(1, OP_ADD, 0, 1);
        for (int k = 0; k < 4; k++) cycle(1, OP_ADD, 0, 1);
        @(negedge clock);
        run = 1'b1;
        #1;
        chk("add_t4_step", 32'(step), 32'd4);
        chk("add_t4_ctl", 32'(ctl), 32'(B_GRC | B_ROUT | B_ZIN));
        chk("add_t4_alu", 32'(alu_op), 32'(ALU_ADD));
        #1;
        clear = 1'b0;
        #1;
        chk("clr_async_ctl", 32'(ctl), 32'd0);
        chk("clr_async_step", 32'(step), 32'd0);
        model_reset();
        @(negedge clock);
        clear = 1'b1;
        run   = 1'b0;

        // ST with run dropped in T6: write still completes, then IDLE, then resume
        cycle(1, OP_ST, 0, 1);
        for (int k = 0; k < 7; k++) cycle(k != 6, OP_ST, 0, 1);
        cycle(0, OP_ST, 0, 1);
        chk("st_t7_step", 32'(last_step), 32'd7);
        chk("st_t7_write", 32'(last_ctl), 32'(B_WRITE));
        cycle(0, OP_ST, 0, 1);
        chk("st_idle_ctl", 32'(last_ctl), 32'd0);
        cycle(1, OP_NOP, 0, 1);
        cycle(1, OP_NOP, 0, 1);
        chk("resume_t0", 32'(last_ctl), 32'(F0));
        cycle(1, OP_NOP, 0, 1);
        cycle(0, OP_NOP, 0, 1);
        cycle(0, OP_NOP, 0, 1);

        // Randomized run against the model
        rop   = OP_NOP;
        stuck = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_mode == MHalt || m_mode == MFault) begin
                stuck++;
                if (stuck > 3) begin
                    do_reset();
                    stuck = 0;
                end
            end
            if (m_mode == MIdle || (m_mode == MRun && m_k == 0)) rop = pick_op();
            cycle($urandom_range(0, 9) != 0, rop, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
